// File: rtl/program_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the program loader.
// master = loader side, slave = byte source / instruction memory side.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, then starts the core.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  program_loader_if.master    ldr_io,
  output logic                proc_hold_o,
  output logic                start_o,
  input  logic                f_done_i,
  output logic                busy_o,
  output logic                load_err_o,
  output logic [ADDR_W:0]     words_loaded_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StLen0, StLen1, StData, StWrite, StStart, StRun, StErr, StChk
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              load_err_q, load_err_d;
  logic [31:0]       tmo_q, tmo_d;

  logic        rx_ready;
  logic        proc_hold;
  logic        start;
  logic        timed_out;
  logic        last_word;
  logic [15:0] len_full;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    byte_idx_d     = byte_idx_q;
    word_idx_d     = word_idx_q;
    word_d         = word_q;
    csum_d         = csum_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = words_loaded_q;
    load_err_d     = load_err_q;
    tmo_d          = '0;
    rx_ready       = 1'b0;
    proc_hold      = 1'b1;
    start          = 1'b0;
    timed_out      = (TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES);
    last_word      = (32'(word_idx_q) + 32'd1) == 32'(len_q);
    len_full       = {ldr_io.rx_data, len_q[7:0]};

    unique case (state_q)
      StLen0: begin
        rx_ready  = 1'b1;
        proc_hold = 1'b0;
        if (ldr_io.rx_valid) begin
          len_d[7:0]     = ldr_io.rx_data;
          words_loaded_d = '0;
          state_d        = StLen1;
        end
      end
      StLen1: begin
        // Ready drops on the timeout cycle so no byte is swallowed by the abort.
        rx_ready = !timed_out;
        tmo_d    = tmo_q + 32'd1;
        if (timed_out) begin
          state_d = StErr;
        end else if (ldr_io.rx_valid) begin
          tmo_d       = '0;
          len_d[15:8] = ldr_io.rx_data;
          if ((len_full == 16'd0) || (32'(len_full) > MAX_WORDS)) begin
            state_d = StErr;
          end else begin
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            state_d    = StData;
          end
        end
      end
      StData: begin
        rx_ready = !timed_out;
        tmo_d    = tmo_q + 32'd1;
        if (timed_out) begin
          state_d = StErr;
        end else if (ldr_io.rx_valid) begin
          tmo_d                        = '0;
          csum_d                       = csum_q ^ ldr_io.rx_data;
          word_d[{byte_idx_q, 3'b000} +: 8] = ldr_io.rx_data;
          byte_idx_d                   = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_wdata_d = {ldr_io.rx_data, word_q[23:0]};
            mem_addr_d  = word_idx_q;
            state_d     = StWrite;
          end
        end
      end
      StWrite: begin
        words_loaded_d = CntW'(word_idx_q) + CntW'(1);
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StStart;
`endif
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = StData;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StChk: begin
        rx_ready = !timed_out;
        tmo_d    = tmo_q + 32'd1;
        if (timed_out) begin
          state_d = StErr;
        end else if (ldr_io.rx_valid) begin
          tmo_d   = '0;
          state_d = (ldr_io.rx_data == csum_q) ? StStart : StErr;
        end
      end
`endif
      StStart: begin
        proc_hold = 1'b0;
        start     = 1'b1;
        state_d   = StRun;
      end
      StRun: begin
        proc_hold = 1'b0;
        if (f_done_i) state_d = StLen0;
      end
      StErr: begin
        state_d = StLen0;
      end
      default: begin
        state_d = StLen0;
      end
    endcase

    // Error flag is visible during the error cycle and cleared as the start pulse goes out.
    if (state_d == StErr) begin
      load_err_d = 1'b1;
    end else if (state_d == StStart) begin
      load_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StLen0;
      len_q          <= '0;
      byte_idx_q     <= '0;
      word_idx_q     <= '0;
      word_q         <= '0;
      csum_q         <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      words_loaded_q <= '0;
      load_err_q     <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_idx_q     <= byte_idx_d;
      word_idx_q     <= word_idx_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      words_loaded_q <= words_loaded_d;
      load_err_q     <= load_err_d;
      tmo_q          <= tmo_d;
    end
  end

  assign ldr_io.rx_ready  = rx_ready;
  assign ldr_io.mem_we    = (state_q == StWrite);
  assign ldr_io.mem_addr  = mem_addr_q;
  assign ldr_io.mem_wdata = mem_wdata_q;
  assign proc_hold_o      = proc_hold;
  assign start_o          = start;
  assign busy_o           = (state_q != StLen0);
  assign load_err_o       = load_err_q;
  assign words_loaded_o   = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal loads, run/done handshake, bad lengths, timeout,
// mid-load reset, maximum-length load and (when built in) the checksum byte.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_done = 1'b0;
  logic        proc_hold, start, busy, load_err;
  logic [10:0] words_loaded;

  int checks = 0;
  int errors = 0;

  program_loader_if #(.ADDR_W(10)) ldr_if ();

  program_loader #(
    .ADDR_W         (10),
    .MAX_WORDS      (1024),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ldr_io         (ldr_if),
    .proc_hold_o    (proc_hold),
    .start_o        (start),
    .f_done_i       (f_done),
    .busy_o         (busy),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  // Write/start monitor sampled on the falling edge.
  int          cyc = 0;
  logic [9:0]  we_addr[$];
  logic [31:0] we_data[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          last_we_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ldr_if.mem_we) begin
        we_addr.push_back(ldr_if.mem_addr);
        we_data.push_back(ldr_if.mem_wdata);
        last_we_cyc = cyc;
      end
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ldr_if.rx_valid = 1'b1;
    ldr_if.rx_data  = b;
    while (ldr_if.rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("send_ready_wait", {63'd0, ldr_if.rx_ready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    ldr_if.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_run();
    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
  endtask

  int we_base;
  int st_base;
  int gap_exp;

  initial begin
    ldr_if.rx_valid = 1'b0;
    ldr_if.rx_data  = 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    gap_exp = 2;
`else
    gap_exp = 1;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rx_ready", {63'd0, ldr_if.rx_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_outputs", {proc_hold, start, load_err, ldr_if.mem_we}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word load, valid every cycle
    we_base = we_addr.size();
    st_base = start_cnt;
    send_byte(8'h02);
    check("len1_hold_busy", {proc_hold, busy}, 64'h3);
    send_byte(8'h00);
    send_word(32'h44332211);
    send_word(32'hDDCCBBAA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    idle(3);
    check("two_we_count", 64'(we_addr.size() - we_base), 64'd2);
    check("two_addr0", {54'd0, we_addr[we_base]}, 64'd0);
    check("two_data0", {32'd0, we_data[we_base]}, 64'h44332211);
    check("two_addr1", {54'd0, we_addr[we_base+1]}, 64'd1);
    check("two_data1", {32'd0, we_data[we_base+1]}, 64'hDDCCBBAA);
    check("two_words_loaded", {53'd0, words_loaded}, 64'd2);
    check("two_start_once", 64'(start_cnt - st_base), 64'd1);
    check("two_start_gap", 64'(start_cyc - last_we_cyc), 64'(gap_exp));
    check("run_hold_busy", {proc_hold, busy}, 64'h1);
    check("run_mem_hold", {22'd0, ldr_if.mem_addr, ldr_if.mem_wdata}, {22'd0, 10'd1, 32'hDDCCBBAA});

    // Bytes offered while running are refused
    ldr_if.rx_valid = 1'b1;
    ldr_if.rx_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run_rx_ready", {63'd0, ldr_if.rx_ready}, 64'd0);
    end
    ldr_if.rx_valid = 1'b0;
    finish_run();
    check("done_rx_ready", {63'd0, ldr_if.rx_ready}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd0);

    // Zero length
    we_base = we_addr.size();
    st_base = start_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    check("len0_err", {proc_hold, load_err}, 64'h3);
    idle(1);
    check("len0_back_idle", {63'd0, busy}, 64'd0);
    check("len0_words_cleared", {53'd0, words_loaded}, 64'd0);

    // Length 1025 > MAX_WORDS
    send_byte(8'h01);
    send_byte(8'h04);
    idle(2);
    check("len_big_err", {63'd0, load_err}, 64'd1);
    check("len_big_idle", {63'd0, busy}, 64'd0);
    check("bad_len_no_we", 64'(we_addr.size() - we_base), 64'd0);
    check("bad_len_no_start", 64'(start_cnt - st_base), 64'd0);

    // Timeout after a partial word
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(7);
    check("tmo_not_early", {ldr_if.rx_ready, busy}, 64'h3);
    idle(4);
    check("tmo_aborted", {busy, load_err}, 64'h1);
    check("tmo_no_we", 64'(we_addr.size() - we_base), 64'd0);

    // Valid one-word load clears the sticky error at its start pulse
    send_byte(8'h01);
    send_byte(8'h00);
    check("err_sticky", {63'd0, load_err}, 64'd1);
    send_word(32'h44556677);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(3);
    check("one_err_cleared", {63'd0, load_err}, 64'd0);
    check("one_start", 64'(start_cnt - st_base), 64'd1);
    check("one_write", {22'd0, we_addr[$], we_data[$]}, {22'd0, 10'd0, 32'h44556677});
    finish_run();

    // Maximum length: 1024 words, word i holds i
    we_base = we_addr.size();
    st_base = start_cnt;
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 1024; i++) send_word(32'(i));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(3);
    check("max_we_count", 64'(we_addr.size() - we_base), 64'd1024);
    check("max_first", {22'd0, we_addr[we_base], we_data[we_base]}, 64'd0);
    check("max_last", {22'd0, we_addr[$], we_data[$]}, {22'd0, 10'h3FF, 32'h3FF});
    check("max_words_loaded", {53'd0, words_loaded}, 64'd1024);
    check("max_start", 64'(start_cnt - st_base), 64'd1);
    finish_run();

    // Reset in the middle of a word
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hDE);
    send_byte(8'hAD);
    ldr_if.rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_busy", {ldr_if.rx_ready, busy}, 64'h2);
    check("mid_rst_flags", {proc_hold, start, load_err, ldr_if.mem_we}, 64'd0);
    check("mid_rst_words", {53'd0, words_loaded}, 64'd0);
    check("mid_rst_mem", {22'd0, ldr_if.mem_addr, ldr_if.mem_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    st_base = start_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hEFBEADDE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    idle(3);
    check("post_rst_write", {22'd0, we_addr[$], we_data[$]}, {22'd0, 10'd0, 32'hEFBEADDE});
    check("post_rst_start", 64'(start_cnt - st_base), 64'd1);
    finish_run();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    st_base = start_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h08040201);
    send_byte(8'h0F);
    idle(2);
    check("csum_ok_start", 64'(start_cnt - st_base), 64'd1);
    check("csum_ok_err", {63'd0, load_err}, 64'd0);
    finish_run();
    st_base = start_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h08040201);
    send_byte(8'h0E);
    idle(2);
    check("csum_bad_err", {63'd0, load_err}, 64'd1);
    check("csum_bad_start", 64'(start_cnt - st_base), 64'd0);
    check("csum_bad_idle", {63'd0, busy}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
